// File: rtl/thermo_pos_decoder_if.sv
// Handshake and data bundle between a mask-pair producer and the position decoder.
// The parameters must match the ones given to thermo_pos_decoder.
interface thermo_pos_decoder_if #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32
);
    localparam int XW = $clog2(WIDTH) + 1;
    localparam int YW = $clog2(HEIGHT) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  x_therm;
    logic [HEIGHT-1:0] y_therm;
    logic [2:0]        patch_size;
    logic              out_valid;
    logic              out_ready;
    logic [XW-1:0]     x_pos;
    logic [YW-1:0]     y_pos;
    logic              pos_err;
    logic [9:0]        patch_idx;
    logic              last;
    logic              sweep_done;
    logic [7:0]        err_count;

    modport master (
        output in_valid, x_therm, y_therm, patch_size, out_ready,
        input  in_ready, out_valid, x_pos, y_pos, pos_err, patch_idx, last,
               sweep_done, err_count
    );

    modport slave (
        input  in_valid, x_therm, y_therm, patch_size, out_ready,
        output in_ready, out_valid, x_pos, y_pos, pos_err, patch_idx, last,
               sweep_done, err_count
    );
endinterface

// File: rtl/thermo_pos_decoder.sv
// Decodes x/y thermometer mask pairs into patch coordinates through a two-stage
// valid/ready pipeline, tracking the patch index within a sweep and errored masks.
module thermo_pos_decoder #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    thermo_pos_decoder_if.slave   bus
);
    localparam int XW = $clog2(WIDTH) + 1;
    localparam int YW = $clog2(HEIGHT) + 1;

    logic              a_valid;
    logic [WIDTH-1:0]  a_x;
    logic [HEIGHT-1:0] a_y;
    logic [2:0]        a_ps;

    logic              b_valid;
    logic [XW-1:0]     x_pos_q;
    logic [YW-1:0]     y_pos_q;
    logic              err_q;
    logic              last_q;
    logic [9:0]        patch_idx_q;
    logic [7:0]        err_count_q;
    logic              sweep_q;

    logic              b_ready;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;

    logic [XW-1:0]     dx_cnt;
    logic [YW-1:0]     dy_cnt;
    logic              dx_err;
    logic              dy_err;
    logic              x_zero_seen;
    logic              y_zero_seen;
    logic              d_last;
    int                y_lim;

    assign b_ready  = !b_valid || bus.out_ready;
    assign in_ready = !rst && (!a_valid || b_ready);
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = b_valid && bus.out_ready;

    // Leading-ones count; any set bit past the first zero marks the mask illegal.
    always_comb begin
        dx_cnt      = '0;
        dx_err      = 1'b0;
        x_zero_seen = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!a_x[i])
                x_zero_seen = 1'b1;
            else if (x_zero_seen)
                dx_err = 1'b1;
            else
                dx_cnt = dx_cnt + XW'(1);
        end
    end

    always_comb begin
        dy_cnt      = '0;
        dy_err      = 1'b0;
        y_zero_seen = 1'b0;
        for (int i = 0; i < HEIGHT; i++) begin
            if (!a_y[i])
                y_zero_seen = 1'b1;
            else if (y_zero_seen)
                dy_err = 1'b1;
            else
                dy_cnt = dy_cnt + YW'(1);
        end
    end

    // Signed compare so a patch larger than the image cannot wrap the limit.
    always_comb begin
        y_lim  = HEIGHT - int'(a_ps);
        d_last = !(dx_err || dy_err) && (int'(dx_cnt) == WIDTH) &&
                 (int'(dy_cnt) >= y_lim);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid     <= 1'b0;
            a_x         <= '0;
            a_y         <= '0;
            a_ps        <= '0;
            b_valid     <= 1'b0;
            x_pos_q     <= '0;
            y_pos_q     <= '0;
            err_q       <= 1'b0;
            last_q      <= 1'b0;
            patch_idx_q <= '0;
            err_count_q <= '0;
            sweep_q     <= 1'b0;
        end else begin
            if (in_fire) begin
                a_valid <= 1'b1;
                a_x     <= bus.x_therm;
                a_y     <= bus.y_therm;
                a_ps    <= bus.patch_size;
            end else if (b_ready) begin
                a_valid <= 1'b0;
            end

            if (b_ready) begin
                b_valid <= a_valid;
                if (a_valid) begin
                    x_pos_q <= dx_cnt;
                    y_pos_q <= dy_cnt;
                    err_q   <= dx_err || dy_err;
                    last_q  <= d_last;
                end
            end

            sweep_q <= out_fire && last_q;

            if (out_fire) begin
                patch_idx_q <= last_q ? 10'd0 : patch_idx_q + 10'd1;
                if (err_q && (err_count_q != 8'hFF))
                    err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    // Outputs are forced low while rst is high, before the first reset edge too.
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = b_valid && !rst;
    assign bus.x_pos      = rst ? '0 : x_pos_q;
    assign bus.y_pos      = rst ? '0 : y_pos_q;
    assign bus.pos_err    = err_q && !rst;
    assign bus.last       = last_q && !rst;
    assign bus.patch_idx  = rst ? '0 : patch_idx_q;
    assign bus.err_count  = rst ? '0 : err_count_q;
    assign bus.sweep_done = sweep_q && !rst;
endmodule

// File: tb/tb_thermo_pos_decoder.sv
// Randomized and directed bench for thermo_pos_decoder against a queue-based
// reference model computed from the mask decoding rules.
module tb_thermo_pos_decoder;
    localparam int W = 32;
    localparam int H = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    thermo_pos_decoder_if #(.WIDTH(W), .HEIGHT(H)) bus();
    thermo_pos_decoder #(.WIDTH(W), .HEIGHT(H)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int xp;
        int yp;
        bit err;
        bit last;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int m_idx  = 0;
    int m_err  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] therm(input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return m[31:0];
    endfunction

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int ps);
        exp_t e;
        int nx = 0;
        int ny = 0;
        while (nx < W && x[nx]) nx++;
        while (ny < H && y[ny]) ny++;
        e.xp   = nx;
        e.yp   = ny;
        e.err  = (x != therm(nx)) || (y != therm(ny));
        e.last = !e.err && (nx == W) && (ny >= H - ps);
        e.cyc  = 0;
        return e;
    endfunction

    task automatic gen(input int kind, output logic [31:0] x, output logic [31:0] y, output int ps);
        int n;
        if (kind == 1) begin
            n = $urandom_range(0, 30);
            x = therm(n) | (32'd1 << $urandom_range(n + 1, 31));
            y = therm($urandom_range(0, 32));
        end else begin
            x = therm(($urandom_range(0, 1) == 1) ? 32 : $urandom_range(0, 32));
            y = therm(($urandom_range(0, 1) == 1) ? $urandom_range(24, 32) : $urandom_range(0, 32));
            if ($urandom_range(0, 4) == 0) x = x ^ (32'd1 << $urandom_range(0, 31));
            if ($urandom_range(0, 4) == 0) y = y ^ (32'd1 << $urandom_range(0, 31));
        end
        ps = 3 + 2 * $urandom_range(0, 2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_idx = 0;
        m_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid   = 1'b1;
        bus.x_therm    = $urandom;
        bus.y_therm    = $urandom;
        bus.patch_size = 3'd3;
        bus.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %0b expected 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.sweep_done !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got out_valid=%0b sweep_done=%0b expected 0 0", bus.out_valid, bus.sweep_done);
        end
        checks++;
        if (bus.x_pos !== 0 || bus.y_pos !== 0 || bus.pos_err !== 1'b0 || bus.last !== 1'b0 ||
            bus.patch_idx !== 0 || bus.err_count !== 0) begin
            errors++; $display("FAIL reset_data: got x=%0d y=%0d err=%0b last=%0b idx=%0d cnt=%0d expected all 0",
                bus.x_pos, bus.y_pos, bus.pos_err, bus.last, bus.patch_idx, bus.err_count);
        end
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset: got in_ready=%0b out_valid=%0b expected 1 0", bus.in_ready, bus.out_valid);
        end
        model_reset();
    endtask

    task automatic test_basic();
        tick();
        bus.in_valid   = 1'b1;
        bus.x_therm    = 32'h0000_00FF;
        bus.y_therm    = 32'h0000_0007;
        bus.patch_size = 3'd3;
        bus.out_ready  = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_in_ready: got %0b expected 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early: got out_valid=%0b expected 0", bus.out_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.x_pos !== 8 || bus.y_pos !== 3 || bus.pos_err !== 1'b0 ||
            bus.last !== 1'b0 || bus.patch_idx !== 0) begin
            errors++; $display("FAIL basic_decode: got v=%0b x=%0d y=%0d err=%0b last=%0b idx=%0d expected 1 8 3 0 0 0",
                bus.out_valid, bus.x_pos, bus.y_pos, bus.pos_err, bus.last, bus.patch_idx);
        end
        tick();
        m_idx = 1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.patch_idx !== m_idx) begin
            errors++; $display("FAIL basic_drain: got v=%0b idx=%0d expected 0 %0d", bus.out_valid, bus.patch_idx, m_idx);
        end
    endtask

    task automatic test_stream(input int n, input int rmode, input int kind);
        int sent = 0;
        int cnt = 0;
        int guard = 0;
        int cps = 3;
        bit have = 0;
        bit sd_exp = 0;
        bit stall = 0;
        int h_x, h_y, h_idx, h_cnt;
        bit h_err, h_last;
        logic [31:0] cx = '0;
        logic [31:0] cy = '0;
        exp_t e;
        while ((sent < n || exp_q.size() > 0 || sd_exp) && guard < n * 20 + 100) begin
            tick();
            guard++;
            if (sent < n && !have) begin
                gen(kind, cx, cy, cps);
                have = 1;
            end
            bus.in_valid   = have && (rmode == 0 || $urandom_range(0, 3) != 0);
            bus.x_therm    = cx;
            bus.y_therm    = cy;
            bus.patch_size = 3'(cps);
            bus.out_ready  = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (bus.sweep_done !== sd_exp) begin
                errors++; $display("FAIL stream_sweep_done: got %0b expected %0b", bus.sweep_done, sd_exp);
            end
            sd_exp = 0;
            checks++;
            if (bus.in_ready !== !(cnt == 2 && !bus.out_ready)) begin
                errors++; $display("FAIL stream_in_ready: got %0b expected %0b (in flight %0d)",
                    bus.in_ready, !(cnt == 2 && !bus.out_ready), cnt);
            end
            if (stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.x_pos !== h_x || bus.y_pos !== h_y || bus.pos_err !== h_err ||
                    bus.last !== h_last || bus.patch_idx !== h_idx || bus.err_count !== h_cnt) begin
                    errors++; $display("FAIL stream_stall: got v=%0b x=%0d y=%0d expected held 1 %0d %0d",
                        bus.out_valid, bus.x_pos, bus.y_pos, h_x, h_y);
                end
            end
            if (bus.out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_extra: got out_valid=1 expected no pending output");
                end else begin
                    e = exp_q[0];
                    if (bus.x_pos !== e.xp || bus.y_pos !== e.yp || bus.pos_err !== e.err || bus.last !== e.last) begin
                        errors++; $display("FAIL stream_data: got x=%0d y=%0d err=%0b last=%0b expected %0d %0d %0b %0b",
                            bus.x_pos, bus.y_pos, bus.pos_err, bus.last, e.xp, e.yp, e.err, e.last);
                    end
                    checks++;
                    if (bus.patch_idx !== m_idx || bus.err_count !== m_err) begin
                        errors++; $display("FAIL stream_counters: got idx=%0d cnt=%0d expected %0d %0d",
                            bus.patch_idx, bus.err_count, m_idx, m_err);
                    end
                    if (rmode == 0) begin
                        checks++;
                        if (cyc - e.cyc != 2) begin
                            errors++; $display("FAIL stream_latency: got %0d cycles expected 2", cyc - e.cyc);
                        end
                    end
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        cnt--;
                        m_idx = e.last ? 0 : (m_idx + 1) % 1024;
                        if (e.err && m_err < 255) m_err++;
                        sd_exp = e.last;
                    end
                end
            end
            stall = bus.out_valid && !bus.out_ready;
            h_x = bus.x_pos; h_y = bus.y_pos; h_err = bus.pos_err; h_last = bus.last;
            h_idx = bus.patch_idx; h_cnt = bus.err_count;
            if (bus.in_valid && bus.in_ready) begin
                e = model(cx, cy, cps);
                e.cyc = cyc;
                exp_q.push_back(e);
                cnt++;
                sent++;
                have = 0;
            end
        end
        bus.in_valid = 1'b0;
        if (guard >= n * 20 + 100) begin
            checks++; errors++;
            $display("FAIL stream_timeout: got %0d sent %0d pending expected all drained", sent, exp_q.size());
        end
    endtask

    task automatic test_illegal();
        tick();
        bus.in_valid   = 1'b1;
        bus.x_therm    = 32'h0000_0105;
        bus.y_therm    = 32'h0000_0007;
        bus.patch_size = 3'd3;
        bus.out_ready  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.x_pos !== 1 || bus.pos_err !== 1'b1 || bus.err_count !== m_err) begin
            errors++; $display("FAIL illegal_decode: got v=%0b x=%0d err=%0b cnt=%0d expected 1 1 1 %0d",
                bus.out_valid, bus.x_pos, bus.pos_err, bus.err_count, m_err);
        end
        tick();
        m_idx++;
        m_err++;
        @(negedge clk);
        checks++;
        if (bus.err_count !== 1) begin
            errors++; $display("FAIL illegal_count: got %0d expected 1", bus.err_count);
        end
        test_stream(300, 0, 1);
        checks++;
        if (bus.err_count !== 255) begin
            errors++; $display("FAIL illegal_saturate: got %0d expected 255", bus.err_count);
        end
    endtask

    task automatic test_sweep();
        tick();
        bus.in_valid   = 1'b1;
        bus.x_therm    = 32'hFFFF_FFFF;
        bus.y_therm    = 32'h1FFF_FFFF;
        bus.patch_size = 3'd3;
        bus.out_ready  = 1'b1;
        tick();
        bus.x_therm    = 32'h0000_000F;
        bus.y_therm    = 32'h0000_0003;
        bus.patch_size = 3'd5;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.last !== 1'b1 || bus.x_pos !== 32 || bus.y_pos !== 29 ||
            bus.patch_idx !== m_idx || bus.sweep_done !== 1'b0) begin
            errors++; $display("FAIL sweep_last: got v=%0b last=%0b x=%0d y=%0d idx=%0d sd=%0b expected 1 1 32 29 %0d 0",
                bus.out_valid, bus.last, bus.x_pos, bus.y_pos, bus.patch_idx, bus.sweep_done, m_idx);
        end
        tick();
        m_idx = 0;
        @(negedge clk);
        checks++;
        if (bus.sweep_done !== 1'b1 || bus.out_valid !== 1'b1 || bus.patch_idx !== 0 || bus.last !== 1'b0 || bus.x_pos !== 4) begin
            errors++; $display("FAIL sweep_pulse: got sd=%0b v=%0b idx=%0d last=%0b x=%0d expected 1 1 0 0 4",
                bus.sweep_done, bus.out_valid, bus.patch_idx, bus.last, bus.x_pos);
        end
        tick();
        m_idx = 1;
        @(negedge clk);
        checks++;
        if (bus.sweep_done !== 1'b0 || bus.out_valid !== 1'b0 || bus.patch_idx !== m_idx) begin
            errors++; $display("FAIL sweep_end: got sd=%0b v=%0b idx=%0d expected 0 0 %0d",
                bus.sweep_done, bus.out_valid, bus.patch_idx, m_idx);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.x_therm    = 32'h0000_FFFF;
        bus.y_therm    = 32'h0000_00FF;
        bus.patch_size = 3'd5;
        tick();
        bus.x_therm    = 32'h0000_0105;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_full: got v=%0b in_ready=%0b expected 1 0", bus.out_valid, bus.in_ready);
        end
        tick();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_during: got v=%0b in_ready=%0b expected 0 0", bus.out_valid, bus.in_ready);
        end
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.patch_idx !== 0 || bus.err_count !== 0) begin
                errors++; $display("FAIL mid_after: got v=%0b idx=%0d cnt=%0d expected 0 0 0",
                    bus.out_valid, bus.patch_idx, bus.err_count);
            end
            tick();
        end
        bus.in_valid   = 1'b1;
        bus.x_therm    = 32'hFFFF_FFFF;
        bus.y_therm    = 32'hFFFF_FFFF;
        bus.patch_size = 3'd7;
        tick();
        bus.in_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.last !== 1'b1) begin
            errors++; $display("FAIL mid_sweep_setup: got v=%0b last=%0b expected 1 1", bus.out_valid, bus.last);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.sweep_done !== 1'b0) begin
            errors++; $display("FAIL mid_sweep_suppress: got %0b expected 0", bus.sweep_done);
        end
        tick();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (bus.sweep_done !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_sweep_after: got sd=%0b v=%0b in_ready=%0b expected 0 0 1",
                bus.sweep_done, bus.out_valid, bus.in_ready);
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.x_therm    = '0;
        bus.y_therm    = '0;
        bus.patch_size = 3'd3;
        bus.out_ready  = 1'b1;
        test_reset();
        test_basic();
        test_illegal();
        test_sweep();
        test_stream(8, 1, 0);
        test_stream(200, 0, 0);
        test_stream(200, 1, 0);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
